// File: rtl/qpu_dtcm_mp_ctrl.sv
// Multi-port DTCM controller: round-robin arbitration of NPORT ICB masters onto one single-port SRAM.
// Optional out-of-range address checking is enabled by defining QPU_DTCM_MP_ADDR_CHK_EN.
module qpu_dtcm_mp_ctrl #(
    parameter int NPORT  = 2,
    parameter int DW     = 32,
    parameter int MW     = DW / 8,
    parameter int AW     = 16,
    parameter int DEPTH  = 4096,
    parameter int RAM_AW = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tcm_cgstop,
    input  logic                test_mode,
    input  logic [NPORT-1:0]    i_icb_cmd_valid,
    output logic [NPORT-1:0]    i_icb_cmd_ready,
    input  logic [NPORT-1:0]    i_icb_cmd_read,
    input  logic [NPORT*AW-1:0] i_icb_cmd_addr,
    input  logic [NPORT*DW-1:0] i_icb_cmd_wdata,
    input  logic [NPORT*MW-1:0] i_icb_cmd_wmask,
    output logic [NPORT-1:0]    i_icb_rsp_valid,
    input  logic [NPORT-1:0]    i_icb_rsp_ready,
    output logic [NPORT*DW-1:0] i_icb_rsp_rdata,
    output logic [NPORT-1:0]    i_icb_rsp_err,
    output logic                ram_cs,
    output logic                ram_we,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [MW-1:0]       ram_wem,
    output logic [DW-1:0]       ram_din,
    input  logic [DW-1:0]       ram_dout,
    output logic                clk_ram,
    output logic                dtcm_active
);

    localparam int BW = $clog2(MW);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
`ifdef QPU_DTCM_MP_ADDR_CHK_EN
    localparam logic [AW-1:0] HI_MASK = {AW{1'b1}} << (RAM_AW + BW);
`endif

    logic [NPORT-1:0] pend_r;
    logic [NPORT-1:0] hold_vld_r;
    logic [NPORT-1:0] hold_err_r;
    logic [DW-1:0]    hold_data_r [NPORT];
    logic             s1_vld_r;
    logic             s1_read_r;
    logic             s1_err_r;
    logic [PW-1:0]    s1_port_r;
    logic [PW-1:0]    rr_ptr_r;

    logic [NPORT-1:0] s1_sel_s;
    logic [NPORT-1:0] rsp_vld_s;
    logic [NPORT-1:0] rsp_hs_s;
    logic [NPORT-1:0] elig_s;
    logic [NPORT-1:0] grant_s;
    logic [PW-1:0]    gnt_idx_s;
    logic             gnt_any_s;
    logic             gnt_read_s;
    logic             gnt_oor_s;
    logic [DW-1:0]    s1_rdata_s;
    logic             cg_en_s;
    logic             cg_en_lat;
    logic             unused_addr_s;

    assign unused_addr_s = ^i_icb_cmd_addr;

    // Response presentation: hold buffer has priority, else the stage-1 result straight from the SRAM.
    always_comb begin
        s1_rdata_s      = (s1_read_r && !s1_err_r) ? ram_dout : '0;
        i_icb_rsp_rdata = '0;
        i_icb_rsp_err   = '0;
        for (int p = 0; p < NPORT; p++) begin
            s1_sel_s[p]  = s1_vld_r && (s1_port_r == PW'(p));
            rsp_vld_s[p] = s1_sel_s[p] | hold_vld_r[p];
            if (hold_vld_r[p]) begin
                i_icb_rsp_rdata[p*DW +: DW] = hold_data_r[p];
                i_icb_rsp_err[p]            = hold_err_r[p];
            end else if (s1_sel_s[p]) begin
                i_icb_rsp_rdata[p*DW +: DW] = s1_rdata_s;
                i_icb_rsp_err[p]            = s1_err_r;
            end else begin
                i_icb_rsp_rdata[p*DW +: DW] = '0;
                i_icb_rsp_err[p]            = 1'b0;
            end
        end
        rsp_hs_s = rsp_vld_s & i_icb_rsp_ready;
        elig_s   = i_icb_cmd_valid & (~pend_r | rsp_hs_s);
    end

    assign i_icb_rsp_valid = rsp_vld_s;

    // Round-robin pick: first eligible port at or after rr_ptr, wrapping cyclically.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        for (int i = 0; i < NPORT; i++) begin
            int idx;
            idx = int'(rr_ptr_r) + i;
            if (idx >= NPORT) begin
                idx = idx - NPORT;
            end else begin
                idx = idx;
            end
            if (!gnt_any_s && elig_s[PW'(idx)]) begin
                gnt_any_s = 1'b1;
                gnt_idx_s = PW'(idx);
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
        grant_s    = gnt_any_s ? (NPORT'(1) << gnt_idx_s) : '0;
        gnt_read_s = i_icb_cmd_read[gnt_idx_s];
`ifdef QPU_DTCM_MP_ADDR_CHK_EN
        gnt_oor_s  = gnt_any_s && |(i_icb_cmd_addr[gnt_idx_s*AW +: AW] & HI_MASK);
`else
        gnt_oor_s  = 1'b0;
`endif
    end

    assign i_icb_cmd_ready = grant_s;

    // SRAM command drive; an out-of-range access leaves the SRAM untouched.
    always_comb begin
        ram_cs   = gnt_any_s && !gnt_oor_s;
        ram_we   = ram_cs && !gnt_read_s;
        ram_addr = ram_cs ? i_icb_cmd_addr[gnt_idx_s*AW + BW +: RAM_AW] : '0;
        ram_wem  = ram_we ? i_icb_cmd_wmask[gnt_idx_s*MW +: MW] : '0;
        ram_din  = ram_cs ? i_icb_cmd_wdata[gnt_idx_s*DW +: DW] : '0;
    end

    // Pending flags, arbitration pointer, stage-1 and per-port response hold buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r     <= '0;
            hold_vld_r <= '0;
            hold_err_r <= '0;
            s1_vld_r   <= 1'b0;
            s1_read_r  <= 1'b0;
            s1_err_r   <= 1'b0;
            s1_port_r  <= '0;
            rr_ptr_r   <= '0;
            for (int p = 0; p < NPORT; p++) begin
                hold_data_r[p] <= '0;
            end
        end else begin
            pend_r    <= (pend_r & ~rsp_hs_s) | grant_s;
            s1_vld_r  <= gnt_any_s;
            s1_port_r <= gnt_idx_s;
            s1_read_r <= gnt_read_s;
            s1_err_r  <= gnt_oor_s;
            if (!gnt_any_s) begin
                rr_ptr_r <= rr_ptr_r;
            end else if (gnt_idx_s == PW'(NPORT - 1)) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= gnt_idx_s + 1'b1;
            end
            for (int p = 0; p < NPORT; p++) begin
                if (s1_sel_s[p] && !i_icb_rsp_ready[p]) begin
                    hold_vld_r[p]  <= 1'b1;
                    hold_data_r[p] <= s1_rdata_s;
                    hold_err_r[p]  <= s1_err_r;
                end else if (rsp_hs_s[p]) begin
                    hold_vld_r[p]  <= 1'b0;
                end else begin
                    hold_vld_r[p]  <= hold_vld_r[p];
                end
            end
        end
    end

    assign cg_en_s     = ram_cs | tcm_cgstop | test_mode;
    assign dtcm_active = (|i_icb_cmd_valid) | (|pend_r);

    // Glitch-free clock gate: enable sampled while clk is low.
    always_latch begin
        if (!clk) begin
            cg_en_lat <= cg_en_s;
        end
    end

    assign clk_ram = clk & cg_en_lat;

endmodule

// File: tb/tb_qpu_dtcm_mp_ctrl.sv
// Scoreboard bench for qpu_dtcm_mp_ctrl: expected responses queued at grant, checked by a monitor.
module tb_qpu_dtcm_mp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tcm_cgstop, test_mode;
    logic [1:0]  cmd_valid, cmd_ready, cmd_read, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_wdata, rsp_rdata;
    logic [7:0]  cmd_wmask;
    logic        ram_cs, ram_we, clk_ram, dtcm_active;
    logic [11:0] ram_addr;
    logic [3:0]  ram_wem;
    logic [31:0] ram_din, ram_dout;

    logic [31:0] mem [4096];
    logic [32:0] exp_rsp [2];
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qpu_dtcm_mp_ctrl dut (
        .clk(clk), .rst(rst), .tcm_cgstop(tcm_cgstop), .test_mode(test_mode),
        .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(cmd_ready), .i_icb_cmd_read(cmd_read),
        .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
        .i_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready), .i_icb_rsp_rdata(rsp_rdata),
        .i_icb_rsp_err(rsp_err), .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout), .clk_ram(clk_ram),
        .dtcm_active(dtcm_active)
    );

    // SRAM model on the gated clock; output is scrambled on write cycles.
    always @(posedge clk_ram) begin
        if (ram_cs) begin
            if (ram_we) begin
                logic [31:0] w;
                w = mem[ram_addr];
                for (int b = 0; b < 4; b++) begin
                    if (ram_wem[b]) w[b*8 +: 8] = ram_din[b*8 +: 8];
                end
                mem[ram_addr] <= w;
                ram_dout <= $urandom;
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Push the expected response whenever a command handshakes.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid[0] && cmd_ready[0]) q0.push_back(exp_rsp[0]);
            if (cmd_valid[1] && cmd_ready[1]) q1.push_back(exp_rsp[1]);
        end
    end

    // Monitor: compare every response handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                if (rsp_valid[p] && rsp_ready[p]) begin
                    logic [32:0] e;
                    logic        empty;
                    empty = (p == 0) ? (q0.size() == 0) : (q1.size() == 0);
                    if (empty) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp port %0d: got %h expected none", p, rsp_rdata[p*32 +: 32]);
                    end else begin
                        e = (p == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("rsp port%0d", p), {31'd0, rsp_err[p], rsp_rdata[p*32 +: 32]}, {31'd0, e});
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int p, input logic rd, input logic [15:0] a,
                           input logic [31:0] wd, input logic [3:0] wm, input logic [32:0] e);
        cmd_valid[p]          = 1'b1;
        cmd_read[p]           = rd;
        cmd_addr[p*16 +: 16]  = a;
        cmd_wdata[p*32 +: 32] = wd;
        cmd_wmask[p*4 +: 4]   = wm;
        exp_rsp[p]            = e;
    endtask

    task automatic wait_grant(input int p);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = cmd_ready[p];
        end
        chk($sformatf("grant port%0d", p), {63'd0, got}, 64'd1);
    endtask

    task automatic do_one(input int p, input logic rd, input logic [15:0] a,
                          input logic [31:0] wd, input logic [3:0] wm, input logic [32:0] e);
        set_cmd(p, rd, a, wd, wm, e);
        wait_grant(p);
        step();
        cmd_valid[p] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tcm_cgstop = 1'b0; test_mode = 1'b0;
        cmd_valid = '0; cmd_read = '0; cmd_addr = '0; cmd_wdata = '0; cmd_wmask = '0;
        rsp_ready = 2'b11; exp_rsp[0] = '0; exp_rsp[1] = '0;
        repeat (2) step();
        @(negedge clk);
        chk("reset rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("reset cmd_ready", {62'd0, cmd_ready}, 64'd0);
        chk("reset ram_cs", {63'd0, ram_cs}, 64'd0);
        chk("reset dtcm_active", {63'd0, dtcm_active}, 64'd0);
        step();
        rst = 1'b0;
        step();

        // 1: write then back-to-back read on port 0
        set_cmd(0, 1'b0, 16'h0010, 32'hDEADBEEF, 4'hF, 33'h0);
        @(negedge clk);
        chk("t1 wr grant", {62'd0, cmd_ready}, 64'd1);
        chk("t1 wr ram_addr", {52'd0, ram_addr}, 64'd4);
        chk("t1 wr ram_we", {63'd0, ram_we}, 64'd1);
        chk("t1 wr ram_wem", {60'd0, ram_wem}, 64'hF);
        step();
        set_cmd(0, 1'b1, 16'h0010, 32'h0, 4'h0, {1'b0, 32'hDEADBEEF});
        @(negedge clk);
        chk("t1 wr rsp_valid", {63'd0, rsp_valid[0]}, 64'd1);
        chk("t1 rd grant", {62'd0, cmd_ready}, 64'd1);
        chk("t1 rd ram_addr", {52'd0, ram_addr}, 64'd4);
        step();
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1 rd rsp_valid", {63'd0, rsp_valid[0]}, 64'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // 2: both ports request continuously -> alternating grants
        set_cmd(0, 1'b1, 16'h0010, 32'h0, 4'h0, {1'b0, 32'hDEADBEEF});
        set_cmd(1, 1'b1, 16'h0010, 32'h0, 4'h0, {1'b0, 32'hDEADBEEF});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t2 grant %0d", i), {62'd0, cmd_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
            chk($sformatf("t2 ram_cs %0d", i), {63'd0, ram_cs}, 64'd1);
            @(posedge clk);
            #1;
            chk($sformatf("t2 clk_ram %0d", i), {63'd0, clk_ram}, 64'd1);
        end
        cmd_valid = '0;
        repeat (3) step();

        // 3: port 1 response back-pressured while port 0 keeps writing
        do_one(0, 1'b0, 16'h0020, 32'h12345678, 4'hF, 33'h0);
        rsp_ready[1] = 1'b0;
        set_cmd(1, 1'b1, 16'h0020, 32'h0, 4'h0, {1'b0, 32'h12345678});
        wait_grant(1);
        step();
        for (int i = 0; i < 3; i++) begin
            set_cmd(0, 1'b0, 16'h0030 + 16'(4 * i), 32'hC0DE0000 + i, 4'hF, 33'h0);
            @(negedge clk);
            chk($sformatf("t3 rsp_valid1 %0d", i), {63'd0, rsp_valid[1]}, 64'd1);
            chk($sformatf("t3 rdata1 %0d", i), {32'd0, rsp_rdata[63:32]}, 64'h12345678);
            chk($sformatf("t3 cmd_ready %0d", i), {62'd0, cmd_ready}, 64'd1);
            step();
        end
        cmd_valid[0] = 1'b0;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        chk("t3 regrant port1", {62'd0, cmd_ready}, 64'd2);
        step();
        cmd_valid[1] = 1'b0;
        repeat (3) step();

        // 4: byte-masked write
        do_one(0, 1'b0, 16'h0040, 32'hFFFFFFFF, 4'hF, 33'h0);
        do_one(0, 1'b0, 16'h0040, 32'hAABBCCDD, 4'h5, 33'h0);
        do_one(1, 1'b1, 16'h0040, 32'h0, 4'h0, {1'b0, 32'hFFBBFFDD});
        repeat (3) step();

        // 5: reset right after a read grant discards the response
        set_cmd(0, 1'b1, 16'h0040, 32'h0, 4'h0, {1'b0, 32'hFFBBFFDD});
        @(negedge clk);
        chk("t5 grant", {62'd0, cmd_ready}, 64'd1);
        step();
        cmd_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t5 rsp_valid in rst", {62'd0, rsp_valid}, 64'd0);
        step();
        rst = 1'b0;
        q0.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5 rsp_valid idle", {62'd0, rsp_valid}, 64'd0);
            chk("t5 dtcm_active", {63'd0, dtcm_active}, 64'd0);
            @(posedge clk);
            #1;
            chk("t5 clk_ram idle", {63'd0, clk_ram}, 64'd0);
        end
        set_cmd(0, 1'b1, 16'h0040, 32'h0, 4'h0, {1'b0, 32'hFFBBFFDD});
        set_cmd(1, 1'b1, 16'h0040, 32'h0, 4'h0, {1'b0, 32'hFFBBFFDD});
        @(negedge clk);
        chk("t5 rr reset grant", {62'd0, cmd_ready}, 64'd1);
        step();
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        chk("t5 second grant", {62'd0, cmd_ready}, 64'd2);
        step();
        cmd_valid[1] = 1'b0;
        repeat (3) step();

        // 6: address above SRAM range
        do_one(1, 1'b0, 16'h0000, 32'h0BADF00D, 4'hF, 33'h0);
`ifdef QPU_DTCM_MP_ADDR_CHK_EN
        set_cmd(0, 1'b1, 16'h4000, 32'h0, 4'h0, {1'b1, 32'h0});
        @(negedge clk);
        chk("t6 grant", {62'd0, cmd_ready}, 64'd1);
        chk("t6 ram_cs", {63'd0, ram_cs}, 64'd0);
`else
        set_cmd(0, 1'b1, 16'h4000, 32'h0, 4'h0, {1'b0, 32'h0BADF00D});
        @(negedge clk);
        chk("t6 grant", {62'd0, cmd_ready}, 64'd1);
        chk("t6 ram_cs", {63'd0, ram_cs}, 64'd1);
        chk("t6 ram_addr", {52'd0, ram_addr}, 64'd0);
`endif
        step();
        cmd_valid[0] = 1'b0;
        repeat (4) step();

        chk("q0 drained", 64'(q0.size()), 64'd0);
        chk("q1 drained", 64'(q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qpu_dtcm_mp_ctrl.md
Name: qpu_dtcm_mp_ctrl

Overview:
Multi-port DTCM controller. It arbitrates NPORT independent single-transaction ICB masters (LSU, measurement-result writer, debug, ...) onto one single-port DTCM SRAM. Arbitration is round-robin, read latency is one cycle, and each port has its own response hold buffer so back-pressure on one port never stalls the others. It sits between the QPU LSU/peripheral ICB fabric and the DTCM RAM macro, and generates the gated RAM clock.

Parameters:
NPORT, 2, number of ICB master ports (1..8)
DW, 32, data width in bits (multiple of 8)
MW, DW/8, write byte-mask width
AW, 16, ICB byte-address width
DEPTH, 4096, SRAM depth in words (power of 2)
RAM_AW, clog2(DEPTH), SRAM word-address width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
tcm_cgstop  in  1  disable RAM clock gating
test_mode  in  1  forces RAM clock enabled
i_icb_cmd_valid  in  NPORT  per-port command valid
i_icb_cmd_ready  out  NPORT  per-port command ready
i_icb_cmd_read  in  NPORT  1 = read, 0 = write
i_icb_cmd_addr  in  NPORT*AW  byte address, port p at [p*AW +: AW]
i_icb_cmd_wdata  in  NPORT*DW  write data
i_icb_cmd_wmask  in  NPORT*MW  byte enables
i_icb_rsp_valid  out  NPORT  response valid
i_icb_rsp_ready  in  NPORT  response ready
i_icb_rsp_rdata  out  NPORT*DW  read data (0 for writes)
i_icb_rsp_err  out  NPORT  error flag
ram_cs  out  1  SRAM chip select
ram_we  out  1  SRAM write enable
ram_addr  out  RAM_AW  SRAM word address
ram_wem  out  MW  SRAM byte write mask
ram_din  out  DW  SRAM write data
ram_dout  in  DW  SRAM read data, valid the cycle after cs
clk_ram  out  1  gated SRAM clock
dtcm_active  out  1  block busy, for core clock gating

Behaviour:
- Reset: all rsp_valid = 0; rsp_err = 0; rdata hold registers = 0; pend[] = 0; rr_ptr = 0 (port 0 highest priority); s1_vld = 0. Reset mid-transaction discards all in-flight and held responses.
- pend[p] is set on a port-p cmd handshake and cleared on a port-p rsp handshake. If both happen in the same cycle, pend[p] stays 1.
- Port p is eligible if cmd_valid[p] & (!pend[p] | (rsp_valid[p] & rsp_ready[p])).
- Round-robin: among eligible ports, grant the first at or after rr_ptr (cyclic). On a grant to p, rr_ptr <= (p+1) mod NPORT. With no grant, rr_ptr holds. One grant per cycle.
- cmd_ready[p] = grant[p] (combinational). Handshake cycle T:
  - ram_cs = 1, ram_we = !read, ram_addr = addr[RAM_AW+log2(MW)-1 : log2(MW)], ram_wem = read ? 0 : wmask, ram_din = wdata.
  - With no grant, ram_cs = 0 and the other RAM outputs are 0.
- Stage 1, registered at the end of T: s1_vld, s1_port, s1_read, s1_err.
- Response in cycle T+1: rsp_valid[s1_port] = 1; rdata = s1_read ? ram_dout : 0.
  - If the response is not accepted in T+1, the rdata value is captured into hold[s1_port] at the end of T+1. rsp_valid stays asserted and rdata comes from hold until rsp_ready.
  - Payload is stable while valid & !ready.
- Throughput:
  - With rsp_ready held high, one port can complete one transaction per cycle (read latency 1).
  - Different ports interleave freely, and the SRAM is busy every cycle when requests exist.
- Read after write to the same address, from any port, returns the new data: writes are committed at T, so a read at T+1 or later sees them.
- Clock gate:
  - Enable = ram_cs | tcm_cgstop | test_mode, latched on clk low via the codebase gate cell.
  - clk_ram is low when disabled.
- dtcm_active = (|cmd_valid) | (|pend).
- Address bits above the SRAM range are ignored (wrap-around) unless the optional feature is enabled.

Optional Feature:
QPU_DTCM_MP_ADDR_CHK_EN
- Defined:
  - An address with any bit set at or above bit RAM_AW+log2(MW) is out of range.
  - An out-of-range command is still granted and handshaken, but ram_cs = 0 that cycle, so the SRAM is untouched.
  - Its response arrives at T+1 with rsp_err = 1 and rdata = 0.
- Undefined: the check logic is absent, rsp_err is tied 0, and upper address bits wrap.

Test Plan:
1. Port 0 writes 0xDEADBEEF, mask 0xF, to 0x0010. Next cycle it reads 0x0010 with rsp_ready = 1 → write rsp at T+1 with rdata 0; read rsp at T+1 with rdata 0xDEADBEEF; ram_addr = 4.
2. Both ports assert valid every cycle for 6 cycles, rsp_ready = 1 → grants alternate 0,1,0,1,0,1 and ram_cs is high all 6 cycles.
3. Port 1 reads 0x0020 (holding 0x12345678) with rsp_ready = 0 for 3 cycles while port 0 keeps writing other addresses → port 1 rdata stays 0x12345678; cmd_ready[1] = 0 for a new port-1 cmd until its rsp handshake.
4. Byte-masked write of 0xAABBCCDD, mask 0x5, over 0xFFFFFFFF → subsequent read returns 0xFFBBFFDD.
5. rst pulses high one cycle after a read grant → no rsp_valid afterwards, pend = 0, rr_ptr = 0, clk_ram stays low while idle with tcm_cgstop = 0.
6. With macro defined and DEPTH = 4096, read 0x4000 → rsp_err = 1, rdata = 0, ram_cs = 0. Without the macro, the same read returns the contents of word 0.
